scan_test_seq: RTL

SCAN_TEST_SEQ -- requirements
Module: scan_test_seq

---
 rtl/scan_test_seq_pkg.sv | 28 ++
 rtl/scan_test_seq_popcnt.sv | 16 +
 rtl/scan_test_seq.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/scan_test_seq_pkg.sv
// Shared definitions for the scan test sequencer: FSM state codes, test-mode
// encodings and the saturating fail-count adder.
package scan_test_seq_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_SHIFT  = 3'd1;
  localparam logic [2:0] ST_CAPT   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_STROBE = 3'd4;
  localparam logic [2:0] ST_UNLOAD = 3'd5;
  localparam logic [2:0] ST_FIN    = 3'd6;

  typedef enum logic {
    SEQ_STUCK = 1'b0,
    SEQ_IDDQ  = 1'b1
  } seq_mode_e;

  // Wide enough for a popcount over the maximum of 16 chains.
  localparam int POP_W = 5;
  localparam logic [15:0] FAIL_SAT = 16'hFFFF;

  function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [POP_W-1:0] b);
    logic [16:0] s;
    s = {1'b0, a} + 17'(b);
    return s[16] ? FAIL_SAT : s[15:0];
  endfunction

endpackage

// File: rtl/scan_test_seq_popcnt.sv
// Population count of an N-bit miscompare vector.
module seq_popcnt
  import scan_test_seq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     vec_i,
  output logic [POP_W-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) cnt_o = cnt_o + POP_W'(vec_i[i]);
  end

endmodule

// File: rtl/scan_test_seq.sv
// Scan test sequencer: shifts patterns into parallel chains, captures or
// IDDQ-strobes, and counts masked miscompares on the unloading response.
//
// state  | meaning
// IDLE   | waiting for start
// SHIFT  | load pattern pat_num, unload previous response
// CAPT   | one-cycle capture pulse (stuck-at)
// SETTLE | IDDQ settle wait
// STROBE | one-cycle IDDQ measurement strobe
// UNLOAD | unload the final response
// FIN    | one-cycle done pulse
module scan_test_seq
  import scan_test_seq_pkg::*;
#(
  parameter int NCHAIN    = 4,
  parameter int CHLEN     = 64,
  parameter int IDDQ_WAIT = 255
) (
  input  logic              clk,
  input  logic              rstz,
  input  logic              start,
  input  logic              abort,
  input  logic              mode,
  input  logic [15:0]       npat,
  input  logic              pat_valid,
  output logic              pat_ready,
  input  logic [NCHAIN-1:0] pat_data,
  input  logic [NCHAIN-1:0] exp_data,
  input  logic [NCHAIN-1:0] exp_mask,
  output logic              scan_en,
  output logic [NCHAIN-1:0] scan_in,
  input  logic [NCHAIN-1:0] scan_out,
  output logic              capture,
  output logic              iddq_strobe,
  output logic              busy,
  output logic              done,
  output logic [15:0]       pat_num,
  output logic [15:0]       fail_cnt
);

  localparam int SW = (CHLEN > 1) ? $clog2(CHLEN) : 1;
  localparam logic [SW-1:0] SHIFT_LAST  = SW'(CHLEN - 1);
  localparam logic [SW-1:0] SHIFT_ONE   = SW'(1);
  localparam logic [15:0]   SETTLE_LOAD = 16'(IDDQ_WAIT - 1);

  logic [2:0]        state_q, state_d;
  seq_mode_e         mode_q, mode_d;
  logic [15:0]       npat_q, npat_d;
  logic [15:0]       pat_num_q, pat_num_d;
  logic [15:0]       fail_q, fail_d;
  logic [15:0]       settle_q, settle_d;
  logic [SW-1:0]     shcnt_q, shcnt_d;
  logic [NCHAIN-1:0] scan_q, scan_d;

  logic              shifting, accept, cmp_en, last_pat;
  logic [15:0]       pat_inc;
  logic [POP_W-1:0]  miss;

  assign shifting = (state_q == ST_SHIFT) || (state_q == ST_UNLOAD);
  assign accept   = shifting && pat_valid;
  // The first load has no prior response in the chains, so it is not compared.
  assign cmp_en   = accept && !abort && ((pat_num_q != 16'd0) || (state_q == ST_UNLOAD));
  assign pat_inc  = pat_num_q + 16'd1;
  assign last_pat = (pat_inc == npat_q);

  seq_popcnt #(.N(NCHAIN)) u_popcnt (
    .vec_i ((scan_out ^ exp_data) & exp_mask),
    .cnt_o (miss)
  );

  assign pat_ready   = accept;
  assign scan_en     = accept;
  assign scan_in     = accept ? pat_data : scan_q;
  assign capture     = (state_q == ST_CAPT);
  assign iddq_strobe = (state_q == ST_STROBE);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_FIN);
  assign pat_num     = pat_num_q;
  assign fail_cnt    = fail_q;

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    npat_d    = npat_q;
    pat_num_d = pat_num_q;
    fail_d    = fail_q;
    settle_d  = settle_q;
    shcnt_d   = shcnt_q;
    scan_d    = accept ? pat_data : scan_q;
    if (cmp_en) fail_d = sat_add(fail_q, miss);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = seq_mode_e'(mode);
          npat_d    = npat;
          pat_num_d = '0;
          fail_d    = '0;
          shcnt_d   = '0;
          state_d   = (npat == 16'd0) ? ST_FIN : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (accept) begin
          if (shcnt_q == SHIFT_LAST) begin
            shcnt_d = '0;
            if (mode_q == SEQ_IDDQ) begin
              state_d  = ST_SETTLE;
              settle_d = SETTLE_LOAD;
            end else begin
              state_d = ST_CAPT;
            end
          end else begin
            shcnt_d = shcnt_q + SHIFT_ONE;
          end
        end
      end
      ST_SETTLE: begin
        if (settle_q == 16'd0) state_d = ST_STROBE;
        else                   settle_d = settle_q - 16'd1;
      end
      ST_CAPT, ST_STROBE: begin
        pat_num_d = pat_inc;
        state_d   = last_pat ? ST_UNLOAD : ST_SHIFT;
      end
      ST_UNLOAD: begin
        if (accept) begin
          if (shcnt_q == SHIFT_LAST) begin
            shcnt_d = '0;
            state_d = ST_FIN;
          end else begin
            shcnt_d = shcnt_q + SHIFT_ONE;
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      pat_num_d = pat_num_q;
      shcnt_d   = '0;
      settle_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q   <= ST_IDLE;
      mode_q    <= SEQ_STUCK;
      npat_q    <= '0;
      pat_num_q <= '0;
      fail_q    <= '0;
      settle_q  <= '0;
      shcnt_q   <= '0;
      scan_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      npat_q    <= npat_d;
      pat_num_q <= pat_num_d;
      fail_q    <= fail_d;
      settle_q  <= settle_d;
      shcnt_q   <= shcnt_d;
      scan_q    <= scan_d;
    end
  end

endmodule
